div_seq: RTL
============

# div_seq

Sequential restoring divider, the inverse of the team's combinational 4×4 multipliers. It accepts a 2N-bit dividend and an N-bit divisor and produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock. A start/busy/done handshake lets a controller recover multiplier operands, or scale results, without a large combinational divide array.

## Interface
- N, default 4: divisor and remainder width; dividend and quotient are 2N bits.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- dividend  in  2N  numerator; captured on the accepted start.
- divisor  in  N  denominator; captured on the accepted start.
- busy  out  1  high while iterating (RUN state).
- done  out  1  single-cycle completion pulse.
- quotient  out  2N  result; holds until the next completion.
- remainder  out  N  result; holds until the next completion.
- div_by_zero  out  1  divisor was 0 for the current result; see Configuration.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: iterating; count 0..2N-1.
  - DONE: results valid for one cycle; done=1.
- IDLE or DONE, start=1: capture operands, clear the partial remainder r (N+1 bits) and count, go to RUN. Back-to-back start in the DONE cycle is legal.
- IDLE or DONE, start=0: go to IDLE.
- Each RUN cycle performs one restoring step:
  - t = {r[N-1:0], next dividend MSB}.
  - If t ≥ {1'b0, divisor}: r = t − divisor and the quotient bit is 1.
  - Otherwise: r = t and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the working register.
- After the 2N-th step, go to DONE. The quotient and remainder outputs load in the same edge: remainder = r[N-1:0].
- start while busy=1 is ignored; operands are not re-sampled.
- Outputs change only on the transition into DONE (and on reset).
- All arithmetic is unsigned. Invariant: quotient·divisor + remainder = dividend.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Reset mid-RUN aborts the operation: no done pulse, outputs cleared.
- Cycle numbering: edge E0 samples start. busy=1 from after E0 through E2N. done=1 for exactly one cycle after E2N.
- Latency from start to done is 2N+1 cycles, i.e. 9 for N=4.
- Throughput: one operation per 2N+1 cycles when start is held high or reissued in the DONE cycle.
- busy and done are never high simultaneously.

## Configuration
- DIV_SEQ_ZERO_DETECT_EN defined:
  - A divisor of 0 at start skips RUN and goes directly to DONE after E0, so done appears 1 cycle after start.
  - Results: quotient = all ones, remainder = dividend[N-1:0], div_by_zero=1.
  - div_by_zero clears on the next completion with a non-zero divisor.
- DIV_SEQ_ZERO_DETECT_EN undefined:
  - No fast path; a zero divisor runs the full 2N steps.
  - The natural restoring result is identical: quotient all ones, remainder = dividend[N-1:0].
  - div_by_zero is tied 0.

## Test plan
- Basic divide: N=4, dividend=200, divisor=7, start pulse → busy for 8 cycles, done 9 cycles after start; quotient=28, remainder=4.
- Edge values: 255/1 → 255 r0; 0/5 → 0 r0; 255/15 → 17 r0; 15/15 → 1 r0. Back-to-back starts issued in the DONE cycle: each result is correct and each done is a single-cycle pulse.
- Divide by zero: 0xA5/0 → quotient=0xFF, remainder=0x5. With the macro: done 1 cycle after start and div_by_zero=1. Without the macro: done after 9 cycles and div_by_zero=0.
- Start while busy: start 200/7, then assert start with 100/3 at cycle 3 → the second request is ignored; result is 28 r4 and exactly one done pulse.
- Reset mid-operation: rst_n=0 at cycle 4 of RUN → next cycle busy=0, quotient=0, remainder=0, and no done pulse. A subsequent 100/3 → 33 r1.
- Random sweep: all 256×15 non-zero operand pairs → quotient·divisor + remainder = dividend and remainder < divisor.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock; DIV_SEQ_ZERO_DETECT_EN enables the divide-by-zero fast path
module div_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0] LAST = CW'(2*N-1);
    logic [1:0]     state;
    logic [2*N-1:0] w;
    logic [N-1:0]   r, dsr, d;
    logic [N:0]     t;
    logic [CW-1:0]  cnt;
    logic           qb;
    assign busy = state == RUN;
    assign done = state == DONE;
    // w shifts dividend bits out of the MSB while quotient bits enter the LSB
    always_comb begin
        t  = {r, w[2*N-1]};
        qb = t >= {1'b0, dsr};
        d  = qb ? t[N-1:0] - dsr : t[N-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            w           <= '0;
            r           <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == RUN) begin
            w   <= {w[2*N-2:0], qb};
            r   <= d;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state       <= DONE;
                quotient    <= {w[2*N-2:0], qb};
                remainder   <= d;
                div_by_zero <= 1'b0;
            end
        end else if (start) begin
            w     <= dividend;
            dsr   <= divisor;
            r     <= '0;
            cnt   <= '0;
            state <= RUN;
`ifdef DIV_SEQ_ZERO_DETECT_EN
            if (divisor == '0) begin
                state       <= DONE;
                quotient    <= '1;
                remainder   <= dividend[N-1:0];
                div_by_zero <= 1'b1;
            end
`endif
        end else begin
            state <= IDLE;
        end
    end
endmodule
